jtag_scan_sequencer: RTL and testbench
======================================

Name: jtag_scan_sequencer

Overview:
- JTAG master-side sequencer that drives tms/tdi into the tap_controller and captures tdo.
- Accepts one command at a time: TAP reset, IR scan, DR scan or run-test-idle wait.
- Converts each command into the exact per-cycle TMS/TDI stream and returns captured scan data.
- Sits between a host/debug register interface and the TAP, one TAP step per tck cycle.

Parameters:
- MAX_LEN, 32, maximum scan length in bits and width of cmd_data/rsp_data.
- LEN_W, 6, width of cmd_len; must be at least $clog2(MAX_LEN+1).
- TLR_CYCLES, 5, number of tms=1 steps used to force Test-Logic-Reset.

Ports:
- tck  in  1  clock; all state changes on rising edge.
- trst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 RESET, 01 IR_SCAN, 10 DR_SCAN, 11 IDLE_WAIT.
- cmd_len  in  LEN_W  scan length in bits, or wait cycle count.
- cmd_data  in  MAX_LEN  TDI bits, shifted LSB first.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_data  out  MAX_LEN  captured TDO bits, LSB first; unused upper bits are 0.
- tms  out  1  registered TMS to the TAP.
- tdi  out  1  registered TDI to the TAP.
- tdo  in  1  TDO from the TAP.
- tap_state  out  4  mirrored TAP state, debug only.

Behaviour:
- Reset (trst=1 at an edge):
  - Outputs: tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, tap_state=TLR.
  - Any command in flight is aborted; no rsp is produced for it.
- Auto-init after trst deasserts:
  - TLR_CYCLES steps with tms=1, then one step with tms=0, leaving the TAP in Run-Test/Idle (RTI).
  - cmd_ready rises the cycle after the tms=0 step. No rsp is produced for auto-init.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready; cmd_ready drops the next cycle.
  - The first command step is driven in the cycle after acceptance.
  - cmd fields are sampled only at acceptance.
  - rsp_valid pulses for one cycle in the cycle after the final step, with no backpressure.
  - cmd_ready re-asserts in that same cycle, so back-to-back commands are allowed.
- Every command starts and ends in RTI. One step = one cycle with tms/tdi held.
- Effective length L = cmd_len clamped to 1..MAX_LEN for scans.
- FSM states: INIT, IDLE, RST_SEQ, NAV, SHIFT, EXIT, WAIT, DONE.
- DR_SCAN (L+5 steps):
  - tms sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - Then L shift steps with tdi=cmd_data[i]; tms=0, except tms=1 on bit L-1 (Exit1-DR).
  - Then tms=1 (Update-DR), tms=0 (RTI).
- IR_SCAN (L+6 steps): tms 1,1,0,0, then shift/exit/update/RTI exactly as for DR_SCAN.
- tdo capture: tdo is sampled at the end of shift step i into rsp_data[i], for i in 0..L-1.
- tdi outside shift steps is 0.
- RESET: TLR_CYCLES steps tms=1, then one step tms=0; rsp_data=0.
- IDLE_WAIT: cmd_len steps with tms=0. cmd_len=0 gives zero steps, with rsp_valid the cycle after acceptance; rsp_data=0.
- tap_state: follows the standard 16-state TAP graph from the registered tms, updated each step. It must equal RTI whenever cmd_ready=1.
- Simultaneous events:
  - trst overrides everything, including a cmd_valid in the same cycle.
  - cmd_valid while busy is ignored; it is not queued.

Decomposition:
- jtag_pkg holds:
  - tap_state_t enum: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
  - op codes OP_RESET, OP_IR, OP_DR, OP_WAIT.
  - seq_state_t.
- Sub-module tap_state_tracker (tck, trst, tms -> tap_state): pure next-state mirror, reused by the bench as a checker.

Test Plan:
- Release trst at t0 -> tms = 1,1,1,1,1,0 over 6 cycles; cmd_ready=1 on cycle 7; tap_state=RTI.
- DR_SCAN len=8, data=0xA5, TAP bypass-style tdo model echoing tdi delayed one step:
  - Expect 13 steps and tms pattern 1,0,0,0x7,1,1,0.
  - Expect rsp_data=0x4A (capture bit 0 then 0xA5 shifted) and rsp_valid on cycle 14.
- IR_SCAN len=4, data=0x3:
  - Expect tms 1,1,0,0,0,0,0,1,1,0 and tdi 1,1,0,0 in shift steps.
  - Expect tap_state to pass SH_IR, and rsp after 10 steps.
- IDLE_WAIT len=0, then len=3 back-to-back -> first rsp 1 cycle after accept; second gives 3 tms=0 steps then rsp.
- Assert trst mid DR_SCAN (step 6 of 13) -> no rsp_valid; auto-init sequence replays; cmd_ready after 6 cycles.
- DR_SCAN len=0 and len=40 -> treated as L=1 and L=32 respectively; step counts 6 and 37.

Source files
------------

// File: rtl/jtag_scan_sequencer_pkg.sv
// Shared JTAG types: TAP state graph, command opcodes and sequencer FSM states.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_IR    = 2'b01,
        OP_DR    = 2'b10,
        OP_WAIT  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        INIT, IDLE, RST_SEQ, NAV, SHIFT, EXIT, WAIT, DONE
    } seq_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
        tap_state_t n;
        case (s)
            TLR:     n = t ? TLR    : RTI;
            RTI:     n = t ? SEL_DR : RTI;
            SEL_DR:  n = t ? SEL_IR : CAP_DR;
            CAP_DR:  n = t ? EX1_DR : SH_DR;
            SH_DR:   n = t ? EX1_DR : SH_DR;
            EX1_DR:  n = t ? UPD_DR : PAU_DR;
            PAU_DR:  n = t ? EX2_DR : PAU_DR;
            EX2_DR:  n = t ? UPD_DR : SH_DR;
            UPD_DR:  n = t ? SEL_DR : RTI;
            SEL_IR:  n = t ? TLR    : CAP_IR;
            CAP_IR:  n = t ? EX1_IR : SH_IR;
            SH_IR:   n = t ? EX1_IR : SH_IR;
            EX1_IR:  n = t ? UPD_IR : PAU_IR;
            PAU_IR:  n = t ? EX2_IR : PAU_IR;
            EX2_IR:  n = t ? UPD_IR : SH_IR;
            UPD_IR:  n = t ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_scan_sequencer_tap_state_tracker.sv
// Mirrors the 16-state TAP controller from the registered TMS stream.
module tap_state_tracker
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output logic [3:0] tap_state
);

    tap_state_t st_q;

    always_ff @(posedge tck) begin
        if (trst) st_q <= TLR;
        else      st_q <= tap_next(st_q, tms);
    end

    assign tap_state = st_q;

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG master sequencer: turns reset/IR/DR/wait commands into per-tck TMS/TDI steps.
module jtag_scan_sequencer
    import jtag_pkg::*;
#(
    parameter int MAX_LEN    = 32,
    parameter int LEN_W      = 6,
    parameter int TLR_CYCLES = 5
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         tap_state
);

    localparam int TLR_W = $clog2(TLR_CYCLES + 2);
    localparam int CNT_W = (LEN_W > TLR_W) ? LEN_W : TLR_W;
    localparam logic [CNT_W-1:0] TLR_C = CNT_W'(TLR_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    seq_state_t         state, nxt_state;
    op_t                op_q, nxt_op;
    logic [CNT_W-1:0]   cnt, nxt_cnt, len_q, nxt_len;
    logic [MAX_LEN-1:0] data_q, nxt_data, mask_q, nxt_mask, rsp_q, nxt_rsp;
    logic               tms_q, nxt_tms, tdi_q, nxt_tdi;
    logic [CNT_W-1:0]   nav_last;

    // State encodes the step currently on tms/tdi; each edge computes the following step.
    always_comb begin
        nxt_state = state;
        nxt_op    = op_q;
        nxt_cnt   = cnt;
        nxt_len   = len_q;
        nxt_data  = data_q;
        nxt_mask  = mask_q;
        nxt_rsp   = rsp_q;
        nxt_tms   = tms_q;
        nxt_tdi   = 1'b0;
        nav_last  = (op_q == OP_IR) ? CNT_W'(3) : CNT_W'(2);

        case (state)
            INIT: begin
                nxt_cnt = cnt + ONE;
                nxt_tms = (cnt < TLR_C);
                if (cnt == TLR_C + ONE) begin
                    nxt_state = IDLE;
                    nxt_tms   = 1'b0;
                    nxt_cnt   = '0;
                end
            end
            IDLE, DONE: begin
                nxt_state = IDLE;
                nxt_tms   = 1'b0;
                if (cmd_valid) begin
                    nxt_op   = op_t'(cmd_op);
                    nxt_data = cmd_data;
                    nxt_mask = MAX_LEN'(1);
                    nxt_rsp  = '0;
                    nxt_cnt  = '0;
                    nxt_len  = CNT_W'(cmd_len);
                    case (op_t'(cmd_op))
                        OP_RESET: begin
                            nxt_state = RST_SEQ;
                            nxt_tms   = 1'b1;
                        end
                        OP_IR, OP_DR: begin
                            nxt_state = NAV;
                            nxt_tms   = 1'b1;
                            if (cmd_len == '0)
                                nxt_len = ONE;
                            else if (cmd_len > LEN_W'(MAX_LEN))
                                nxt_len = CNT_W'(MAX_LEN);
                        end
                        default: begin
                            nxt_state = (cmd_len == '0) ? DONE : WAIT;
                        end
                    endcase
                end
            end
            RST_SEQ: begin
                if (cnt == TLR_C) begin
                    nxt_state = DONE;
                    nxt_tms   = 1'b0;
                end else begin
                    nxt_cnt = cnt + ONE;
                    nxt_tms = (cnt + ONE < TLR_C);
                end
            end
            NAV: begin
                if (cnt == nav_last) begin
                    nxt_state = SHIFT;
                    nxt_cnt   = '0;
                    nxt_tdi   = data_q[0];
                    nxt_tms   = (len_q == ONE);
                end else begin
                    nxt_cnt = cnt + ONE;
                    nxt_tms = (op_q == OP_IR) && (cnt == '0);
                end
            end
            SHIFT: begin
                if (tdo) nxt_rsp = rsp_q | mask_q;
                nxt_mask = mask_q << 1;
                if (cnt == len_q - ONE) begin
                    nxt_state = EXIT;
                    nxt_cnt   = '0;
                    nxt_tms   = 1'b1;
                end else begin
                    nxt_cnt  = cnt + ONE;
                    nxt_data = data_q >> 1;
                    nxt_tdi  = data_q[1];
                    nxt_tms  = (cnt + CNT_W'(2) == len_q);
                end
            end
            EXIT: begin
                nxt_tms = 1'b0;
                if (cnt == '0) nxt_cnt = ONE;
                else           nxt_state = DONE;
            end
            WAIT: begin
                nxt_tms = 1'b0;
                if (cnt == len_q - ONE) nxt_state = DONE;
                else                    nxt_cnt = cnt + ONE;
            end
            default: nxt_state = INIT;
        endcase
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            state  <= INIT;
            op_q   <= OP_RESET;
            cnt    <= '0;
            len_q  <= '0;
            data_q <= '0;
            mask_q <= '0;
            rsp_q  <= '0;
            tms_q  <= 1'b1;
            tdi_q  <= 1'b0;
        end else begin
            state  <= nxt_state;
            op_q   <= nxt_op;
            cnt    <= nxt_cnt;
            len_q  <= nxt_len;
            data_q <= nxt_data;
            mask_q <= nxt_mask;
            rsp_q  <= nxt_rsp;
            tms_q  <= nxt_tms;
            tdi_q  <= nxt_tdi;
        end
    end

    assign cmd_ready = (state == IDLE) || (state == DONE);
    assign rsp_valid = (state == DONE);
    assign rsp_data  = rsp_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    tap_state_tracker u_tracker (
        .tck       (tck),
        .trst      (trst),
        .tms       (tms_q),
        .tap_state (tap_state)
    );

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer with a one-step tdi->tdo echo TAP model.
module tb_jtag_scan_sequencer;
    import jtag_pkg::*;

    localparam int MAX_LEN    = 32;
    localparam int LEN_W      = 6;
    localparam int TLR_CYCLES = 5;

    logic               tck = 1'b0;
    logic               trst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tms;
    logic               tdi;
    logic               tdo = 1'b0;
    logic [3:0]         tap_state;

    int          total = 0;
    int          bad   = 0;
    int          steps;
    logic [63:0] tms_v, tdi_v;
    logic [3:0]  ts_v [0:63];

    jtag_scan_sequencer #(
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W),
        .TLR_CYCLES (TLR_CYCLES)
    ) dut (
        .tck       (tck),
        .trst      (trst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tap_state (tap_state)
    );

    always #5 tck = ~tck;

    // Bypass-like TAP: tdo presents the tdi of the previous step.
    always @(posedge tck) tdo <= tdi;

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic init_seq(input string tag);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("%s_tms%0d", tag, k), 64'(tms), (k <= 5) ? 64'd1 : 64'd0);
            chk($sformatf("%s_rdy%0d", tag, k), 64'(cmd_ready), 64'd0);
            chk($sformatf("%s_rsp%0d", tag, k), 64'(rsp_valid), 64'd0);
        end
        tick();
        chk({tag, "_ready7"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_rti"}, 64'(tap_state), 64'(RTI));
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [LEN_W-1:0] len,
                           input logic [MAX_LEN-1:0] data, input int exp_steps,
                           input logic [MAX_LEN-1:0] exp_rsp);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_len   = ~len;
        cmd_data  = ~data;
        tms_v     = '0;
        tdi_v     = '0;
        steps     = 0;
        while (!rsp_valid && steps < 64) begin
            tms_v[steps] = tms;
            tdi_v[steps] = tdi;
            ts_v[steps]  = tap_state;
            cmd_valid    = (steps == 2);
            steps++;
            tick();
        end
        cmd_valid = 1'b0;
        chk({tag, "_steps"}, 64'(steps), 64'(exp_steps));
        chk({tag, "_rspv"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rdy"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_rti"}, 64'(tap_state), 64'(RTI));
        chk({tag, "_data"}, 64'(rsp_data), 64'(exp_rsp));
        tick();
        chk({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        trst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) tick();
        chk("rst_tms", 64'(tms), 64'd1);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_rdy", 64'(cmd_ready), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        chk("rst_tap", 64'(tap_state), 64'(TLR));
        trst = 1'b0;
        init_seq("init");

        run_cmd("dr8", 2'b10, 6'd8, 32'hA5, 13, 32'h4A);
        chk("dr8_tms", tms_v, 64'h0C01);
        chk("dr8_tdi", tdi_v, 64'h0528);
        chk("dr8_shdr", 64'(ts_v[3]), 64'(SH_DR));
        chk("dr8_upd", 64'(ts_v[12]), 64'(UPD_DR));

        run_cmd("ir4", 2'b01, 6'd4, 32'h3, 10, 32'h6);
        chk("ir4_tms", tms_v, 64'h0183);
        chk("ir4_tdi", tdi_v, 64'h0030);
        chk("ir4_shir", 64'(ts_v[4]), 64'(SH_IR));
        chk("ir4_upd", 64'(ts_v[9]), 64'(UPD_IR));

        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_len   = 6'd0;
        tick();
        chk("w0_rspv", 64'(rsp_valid), 64'd1);
        chk("w0_rdy", 64'(cmd_ready), 64'd1);
        chk("w0_data", 64'(rsp_data), 64'd0);
        cmd_len = 6'd3;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("w3_rspv%0d", k), 64'(rsp_valid), 64'd0);
            chk($sformatf("w3_tms%0d", k), 64'(tms), 64'd0);
            chk($sformatf("w3_tap%0d", k), 64'(tap_state), 64'(RTI));
            tick();
        end
        chk("w3_rspv", 64'(rsp_valid), 64'd1);
        chk("w3_data", 64'(rsp_data), 64'd0);
        tick();
        chk("w3_pulse", 64'(rsp_valid), 64'd0);

        run_cmd("reset", 2'b00, 6'd0, 32'h0, 6, 32'h0);
        chk("reset_tms", tms_v, 64'h1F);
        chk("reset_tlr", 64'(ts_v[5]), 64'(TLR));

        run_cmd("dr_len0", 2'b10, 6'd0, 32'h1, 6, 32'h0);
        chk("dr_len0_tms", tms_v, 64'h19);
        run_cmd("dr_len40", 2'b10, 6'd40, 32'hFFFF_FFFF, 37, 32'hFFFF_FFFE);
        chk("dr_len40_tms", tms_v, (64'h3 << 34) | 64'h1);

        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_len   = 6'd8;
        cmd_data  = 32'hA5;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        chk("mid_tms6", 64'(tms), 64'd0);
        chk("mid_tap6", 64'(tap_state), 64'(SH_DR));
        trst      = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_len   = 6'd0;
        tick();
        trst      = 1'b0;
        cmd_valid = 1'b0;
        chk("mid_rst_tms", 64'(tms), 64'd1);
        chk("mid_rst_rdy", 64'(cmd_ready), 64'd0);
        chk("mid_rst_rspv", 64'(rsp_valid), 64'd0);
        chk("mid_rst_tap", 64'(tap_state), 64'(TLR));
        init_seq("reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
